// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared constants, entry layout and pointer sizing for the decode queue
package decode_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'hE1A00000;
  localparam int          ENTRY_WIDTH       = 32;

  typedef struct packed {
    logic [ENTRY_WIDTH-1:0] instr;
    logic [ENTRY_WIDTH-1:0] pcplus8;
  } entry_t;

  // Keeps pointers at least one bit wide even for the smallest legal depth.
  function automatic int ptr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/decode_queue_mem.sv
// rtl/decode_queue_mem.sv - entry storage: flop array, synchronous write, asynchronous read
module decode_queue_mem #(
  parameter int EW    = 64,
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic [PW-1:0] raddr,
  output logic [EW-1:0] rdata
);

  logic [EW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - fetch-to-decode instruction FIFO with flush and drop counter
// Define DECODE_QUEUE_BYPASS_EN to forward a fetch straight to decode when the queue is empty.
module decode_queue
  import decode_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(NOP_INSTR_DEFAULT)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       fetch_valid,
  output logic                       fetch_ready,
  input  logic [WIDTH-1:0]           InstrF,
  input  logic [WIDTH-1:0]           PCPlus8F,
  input  logic                       decode_ready,
  output logic                       decode_valid,
  output logic [WIDTH-1:0]           InstrD,
  output logic [WIDTH-1:0]           PCPlus8D,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [7:0]                 flush_drops
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;
  logic [CW-1:0]      cnt;
  logic [7:0]         drops;
  logic [2*WIDTH-1:0] wr_entry;
  logic [2*WIDTH-1:0] rd_entry;
  logic               push;
  logic               pop;
  logic               store;
  logic               advance;
  logic               bypass;
  logic               held;
  logic [31:0]        drop_sum;

  assign held        = (cnt != '0);
  assign fetch_ready = (cnt < CW'(DEPTH)) & ~flush;
  assign push        = fetch_valid & fetch_ready;
  assign pop         = decode_valid & decode_ready;
  assign wr_entry    = {InstrF, PCPlus8F};

`ifdef DECODE_QUEUE_BYPASS_EN
  assign bypass = ~held & fetch_valid & ~flush;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    decode_valid = held;
    InstrD       = NOP_INSTR;
    PCPlus8D     = '0;
    if (bypass) begin
      decode_valid = 1'b1;
      InstrD       = InstrF;
      PCPlus8D     = PCPlus8F;
    end else if (held) begin
      InstrD   = rd_entry[2*WIDTH-1:WIDTH];
      PCPlus8D = rd_entry[WIDTH-1:0];
    end
  end

  // A forwarded instruction that decode takes immediately never occupies a slot.
  assign store   = push & ~(bypass & decode_ready);
  assign advance = pop & ~bypass;

  assign drop_sum = 32'(drops) + 32'(cnt) + 32'(fetch_valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      drops <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      drops <= (drop_sum > 32'd255) ? 8'hFF : drop_sum[7:0];
    end else begin
      if (store) begin
        tail <= tail + 1'b1;
      end
      if (advance) begin
        head <= head + 1'b1;
      end
      case ({store, advance})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  decode_queue_mem #(
    .EW    (2*WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (store & ~flush),
    .waddr (tail),
    .wdata (wr_entry),
    .raddr (head),
    .rdata (rd_entry)
  );

  assign count       = cnt;
  assign flush_drops = drops;

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - randomized scoreboard bench for decode_queue
module tb_decode_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] InstrF;
  logic [31:0] PCPlus8F;
  logic        decode_ready;
  logic        decode_valid;
  logic [31:0] InstrD;
  logic [31:0] PCPlus8D;
  logic [2:0]  count;
  logic [7:0]  flush_drops;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  int          ref_drops;
  int          checks;
  int          errors;
  logic [31:0] next_pc;

  decode_queue #(
    .WIDTH     (32),
    .DEPTH     (DEPTH),
    .NOP_INSTR (NOP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .fetch_valid  (fetch_valid),
    .fetch_ready  (fetch_ready),
    .InstrF       (InstrF),
    .PCPlus8F     (PCPlus8F),
    .decode_ready (decode_ready),
    .decode_valid (decode_valid),
    .InstrD       (InstrD),
    .PCPlus8D     (PCPlus8D),
    .count        (count),
    .flush_drops  (flush_drops)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of stimulus, checks status outputs against the model and
  // records what the queue should eventually hand to decode.
  task automatic step(input logic fv, input logic [31:0] ins, input logic [31:0] pc,
                      input logic dr, input logic fl, output logic accepted);
    int   sz;
    logic exp_valid;
    @(negedge clk);
    fetch_valid  = fv;
    InstrF       = ins;
    PCPlus8F     = pc;
    decode_ready = dr;
    flush        = fl;
    #1;
    sz        = exp_q.size();
    exp_valid = (sz != 0);
`ifdef DECODE_QUEUE_BYPASS_EN
    exp_valid = exp_valid || (sz == 0 && fv && !fl);
`endif
    chk("count", 32'(count), 32'(sz));
    chk("fetch_ready", 32'(fetch_ready), 32'((sz < DEPTH) && !fl));
    chk("decode_valid", 32'(decode_valid), 32'(exp_valid));
    chk("flush_drops", 32'(flush_drops), 32'(ref_drops));
    if (!exp_valid) begin
      chk("idle_instr", InstrD, NOP);
      chk("idle_pc", PCPlus8D, 32'h0);
    end
    accepted = 1'b0;
    if (fl) begin
      ref_drops = (ref_drops + sz + int'(fv) > 255) ? 255 : ref_drops + sz + int'(fv);
      exp_q.delete();
    end else if (fv && sz < DEPTH) begin
      exp_q.push_back('{instr: ins, pc: pc});
      accepted = 1'b1;
    end
  endtask

  task automatic fetch(input logic dr, output logic accepted);
    step(1'b1, $urandom, next_pc, dr, 1'b0, accepted);
    if (accepted) next_pc = next_pc + 32'd4;
  endtask

  task automatic idle(input logic dr);
    logic acc;
    step(1'b0, $urandom, $urandom, dr, 1'b0, acc);
  endtask

  // Scoreboard monitor: every handshake on the decode side consumes the oldest expectation.
  always @(negedge clk) begin
    #2;
    if (reset && !flush && decode_valid && decode_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_underflow: got InstrD %h with no expected entry at %0t", InstrD, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pop_instr", InstrD, e.instr);
        chk("pop_pc", PCPlus8D, e.pc);
      end
    end
  end

  initial begin
    logic acc;
    int   pushed;
    checks       = 0;
    errors       = 0;
    ref_drops    = 0;
    next_pc      = 32'h100;
    reset        = 1'b0;
    flush        = 1'b0;
    fetch_valid  = 1'b0;
    decode_ready = 1'b0;
    InstrF       = '0;
    PCPlus8F     = '0;
    #1;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_valid", 32'(decode_valid), 32'h0);
    chk("rst_instr", InstrD, NOP);
    chk("rst_pc", PCPlus8D, 32'h0);
    chk("rst_drops", 32'(flush_drops), 32'h0);
    #2 reset = 1'b1;

    step(1'b1, 32'hE3A01005, 32'h8, 1'b0, 1'b0, acc);
    idle(1'b1);
    idle(1'b0);

    for (int i = 0; i < 5; i++) fetch(1'b0, acc);
    fetch(1'b1, acc);
    fetch(1'b1, acc);
    fetch(1'b0, acc);
    fetch(1'b1, acc);
    for (int i = 0; i < 6; i++) idle(1'b1);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0)
        step(1'($urandom_range(0, 1)), $urandom, next_pc, 1'($urandom), 1'b1, acc);
      else if ($urandom_range(0, 3) != 0)
        fetch(1'($urandom), acc);
      else
        idle(1'($urandom));
    end
    for (int i = 0; i < 6; i++) idle(1'b1);

    pushed = 0;
    for (int i = 0; i < 40 && (pushed < 10 || exp_q.size() != 0); i++) begin
      if (pushed < 10) begin
        fetch(((i % 2) == 0), acc);
        if (acc) pushed++;
      end else begin
        idle(((i % 2) == 0));
      end
    end
    chk("toggle_pushed", 32'(pushed), 32'd10);
    chk("toggle_drained", 32'(exp_q.size()), 32'd0);

    step(1'b0, $urandom, $urandom, 1'b0, 1'b1, acc);
    idle(1'b0);

    for (int n = 0; n < 70; n++) begin
      for (int i = 0; i < 3; i++) fetch(1'b0, acc);
      step(1'b1, $urandom, next_pc, 1'b0, 1'b1, acc);
    end
    idle(1'b0);
    chk("drops_saturated", 32'(ref_drops), 32'd255);

    fetch(1'b0, acc);
    fetch(1'b0, acc);
    idle(1'b0);
    @(negedge clk);
    fetch_valid  = 1'b0;
    decode_ready = 1'b0;
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'h0);
    chk("mid_rst_valid", 32'(decode_valid), 32'h0);
    chk("mid_rst_instr", InstrD, NOP);
    chk("mid_rst_pc", PCPlus8D, 32'h0);
    chk("mid_rst_drops", 32'(flush_drops), 32'h0);
    chk("mid_rst_ready", 32'(fetch_ready), 32'h1);
    exp_q.delete();
    ref_drops = 0;
    @(negedge clk);
    reset = 1'b1;
    fetch(1'b0, acc);
    idle(1'b1);
    idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter WIDTH, default 32: instruction and PC width in bits.
REQ-002 Parameter DEPTH, default 4: entry count; power of two, minimum 2.
REQ-003 Parameter NOP_INSTR, default 32'hE1A00000: value driven on InstrD when decode_valid is 0.
REQ-004 clk  input  1  rising-edge clock; the block has one clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  discard all held instructions; driven by taken branch/PCSrc resolution.
REQ-007 fetch_valid  input  1  InstrF/PCPlus8F hold a fetched instruction.
REQ-008 fetch_ready  output  1  queue accepts a push this cycle.
REQ-009 InstrF  input  WIDTH  fetched instruction.
REQ-010 PCPlus8F  input  WIDTH  PC+8 paired with InstrF.
REQ-011 decode_ready  input  1  decode consumes the head this cycle (low = stall).
REQ-012 decode_valid  output  1  InstrD/PCPlus8D hold a valid instruction.
REQ-013 InstrD  output  WIDTH  head instruction, or NOP_INSTR when not valid.
REQ-014 PCPlus8D  output  WIDTH  PC+8 of head, or 0 when not valid.
REQ-015 count  output  $clog2(DEPTH+1)  occupied entries.
REQ-016 flush_drops  output  8  saturating count of instructions discarded by flush.

Function
REQ-017 Push = fetch_valid & fetch_ready; pop = decode_valid & decode_ready.
REQ-018 fetch_ready shall be (count < DEPTH) & ~flush; it shall not depend on decode_ready.
REQ-019 decode_valid shall be (count != 0), except as extended by REQ-029.
REQ-020 Each push shall write {InstrF, PCPlus8F} at the tail; each pop shall advance the head; order is strict FIFO.
REQ-021 A pushed instruction shall appear on InstrD no earlier than the following cycle (one-cycle latency when empty).
REQ-022 Simultaneous push and pop shall leave count unchanged; when count==DEPTH, fetch_ready is 0, so a same-cycle pop does not enable a push.
REQ-023 Head/tail pointers shall be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-024 flush shall take priority: the next state shall be count=0 with pointers equal; any same-cycle push or pop is discarded.
REQ-025 On flush, flush_drops shall add count plus 1 if fetch_valid was high, saturating at 255.
REQ-026 A flush with count==0 and fetch_valid low shall leave flush_drops unchanged.
REQ-027 Outputs shall be combinational from registered state (plus inputs only under REQ-029); the block shall have no combinational path from decode_ready to fetch_ready.

Reset
REQ-028 On reset asserted low: count=0, pointers=0, flush_drops=0, decode_valid=0, InstrD=NOP_INSTR, PCPlus8D=0, fetch_ready=1 once released; storage contents need not be reset; reset mid-operation discards all entries immediately.

Configuration
REQ-029 Macro DECODE_QUEUE_BYPASS_EN defined: with count==0, fetch_valid=1 and flush=0, decode_valid=1 and InstrD/PCPlus8D=InstrF/PCPlus8F the same cycle; if decode_ready=1 the entry is not stored, otherwise it is stored normally.
REQ-030 Macro DECODE_QUEUE_BYPASS_EN undefined: no input-to-output combinational path; latency per REQ-021.

Structure
REQ-031 Shared package decode_pkg shall hold NOP_INSTR default, the entry struct {instr, pcplus8}, and the pointer-width helper.
REQ-032 One sub-module decode_queue_mem: DEPTH x entry flop array, synchronous write enable, asynchronous read.

Verification
REQ-033 Reset then push 32'hE3A01005/PC+8 32'h8: cycle+1 decode_valid=1, InstrD=E3A01005, PCPlus8D=8; pop -> count=0, InstrD=E1A00000.
REQ-034 Push 4 with decode_ready=0 -> count=4, fetch_ready=0; 5th fetch_valid ignored; pop+push same cycle keeps count=4 only after fetch_ready returns.
REQ-035 Fill 3, flush with fetch_valid=1 -> next cycle count=0, decode_valid=0, flush_drops=4; 70 such flushes -> flush_drops=255.
REQ-036 Stream 10 instructions with decode_ready toggling 1010...: output order equals input order across pointer wrap.
REQ-037 BYPASS_EN, empty, push E0812003 with decode_ready=1: same-cycle InstrD=E0812003, count stays 0; without macro, valid appears next cycle.
REQ-038 Assert reset mid-stream with count=2: outputs at reset values immediately, without waiting for a clock edge.
